stopwatch_core: RTL and testbench

Time-base and counting datapath for the stopwatch/clock display path. Divides the system clock down to a 100 Hz tick and runs cascaded msec/sec/min/hour counters under a run/stop/clear state machine. Its binary outputs drive the `msec`, `sec`, `min` and `hour` inputs of the FND display controller directly downstream. Button inputs arrive already debounced as single-cycle pulses.

---
 rtl/stopwatch_pkg.sv | 51 +++++
 rtl/tick_gen.sv | 30 +++
 rtl/stopwatch_core.sv | 121 ++++++++++++
 tb/tb_stopwatch_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, field limits and the time cascade helper for the stopwatch.
// Lap hold is built only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } time_t;

    // Full ripple of one hundredth through every field in a single step.
    function automatic time_t time_inc(time_t t);
        time_t n;
        n = t;
        if (t.msec != MSEC_MAX) begin
            n.msec = t.msec + 1'b1;
        end else begin
            n.msec = '0;
            if (t.sec != SEC_MAX) begin
                n.sec = t.sec + 1'b1;
            end else begin
                n.sec = '0;
                if (t.min != MIN_MAX) begin
                    n.min = t.min + 1'b1;
                end else begin
                    n.min  = '0;
                    n.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + 1'b1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock divider producing one tick every DIV enabled cycles.
// Holds its phase while disabled; zeroed by clear.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (clear) begin
            div_q <= '0;
        end else if (enable) begin
            div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign tick = enable && (div_q == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Run/stop/clear FSM and msec/sec/min/hour cascade on a divided tick.
// Optional lap hold snapshot enabled by STOPWATCH_LAP_EN.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int F_CLK   = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run_stop,
    input  logic              i_clear,
    input  logic              i_lap,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_running
);

    localparam int DIV = F_CLK / TICK_HZ;

    state_t state;
    logic   tick;
    time_t  cnt_q;
    time_t  cnt_n;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ST_RUN),
        .clear  (state == ST_CLEAR),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_STOP;
            o_running <= 1'b0;
        end else begin
            case (state)
                ST_STOP: begin
                    if (i_clear) begin
                        state <= ST_CLEAR;
                    end else if (i_run_stop) begin
                        state     <= ST_RUN;
                        o_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_run_stop) begin
                        state     <= ST_STOP;
                        o_running <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_STOP;
                    o_running <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_n = cnt_q;
        if (state == ST_CLEAR) begin
            cnt_n = '0;
        end else if (tick) begin
            cnt_n = time_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic  hold_q;
    logic  hold_n;
    time_t disp_q;

    // Stop wins over a coincident lap; leaving RUN always drops hold.
    always_comb begin
        hold_n = 1'b0;
        if (state == ST_RUN && !i_run_stop) begin
            hold_n = hold_q ^ i_lap;
        end
    end

    // disp_q tracks the live count, so freezing it is the snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            hold_q <= hold_n;
            if (!hold_n) begin
                disp_q <= cnt_n;
            end
        end
    end

    assign o_msec = disp_q.msec;
    assign o_sec  = disp_q.sec;
    assign o_min  = disp_q.min;
    assign o_hour = disp_q.hour;
`else
    logic unused_lap;
    assign unused_lap = i_lap;

    assign o_msec = cnt_q.msec;
    assign o_sec  = cnt_q.sec;
    assign o_min  = cnt_q.min;
    assign o_hour = cnt_q.hour;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with an elapsed-time reference model.
// Lap checks are compiled when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

    localparam int DIV = 10;
    localparam int DAY = 24 * 60 * 60 * 100;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_run_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_lap = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_running;

    int n_tot = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    stopwatch_core #(.F_CLK(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run_stop (i_run_stop),
        .i_clear    (i_clear),
        .i_lap      (i_lap),
        .o_msec     (o_msec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour),
        .o_running  (o_running)
    );

    always #5 clk = ~clk;

    // Model: 0=STOP 1=RUN 2=CLEAR; time kept as total hundredths.
    int m_st, m_ph, m_tot, m_snap;
    bit m_hold;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_ph = 0; m_tot = 0; m_snap = 0; m_hold = 0;
        end else begin
            if (m_st == 1 && !i_run_stop) begin
                if (i_lap) begin
                    if (!m_hold) m_snap = m_tot;
                    m_hold = !m_hold;
                end
            end else begin
                m_hold = 0;
            end
            if (m_st == 1) begin
                m_ph = m_ph + 1;
                if (m_ph == DIV) begin
                    m_ph = 0;
                    m_tot = (m_tot + 1) % DAY;
                end
            end
            case (m_st)
                0: if (i_clear) m_st = 2; else if (i_run_stop) m_st = 1;
                1: if (i_run_stop) m_st = 0;
                default: begin m_st = 0; m_tot = 0; m_ph = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset && chk_en) begin
            int d, e_ms, e_s, e_m, e_h, e_r;
            d = (LAP && m_hold) ? m_snap : m_tot;
            e_ms = d % 100;
            e_s = (d / 100) % 60;
            e_m = (d / 6000) % 60;
            e_h = d / 360000;
            e_r = (m_st == 1) ? 1 : 0;
            n_tot++;
            if (o_msec != e_ms || o_sec != e_s || o_min != e_m ||
                o_hour != e_h || o_running != e_r) begin
                n_bad++;
                $display("FAIL model t=%0t got %0d:%0d:%0d.%0d r=%0b want %0d:%0d:%0d.%0d r=%0d",
                         $time, o_hour, o_min, o_sec, o_msec, o_running,
                         e_h, e_m, e_s, e_ms, e_r);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit rs, input bit clr, input bit lp);
        i_run_stop = rs; i_clear = clr; i_lap = lp;
        @(posedge clk); #1;
        i_run_stop = 0; i_clear = 0; i_lap = 0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic preload(input int h, input int m, input int s, input int ms);
        time_t t;
        t.hour = h[4:0]; t.min = m[5:0]; t.sec = s[5:0]; t.msec = ms[6:0];
        chk_en = 0;
        force dut.cnt_q = t;
        m_tot = ((h * 60 + m) * 60 + s) * 100 + ms;
        wait_edges(1);
        release dut.cnt_q;
        wait_edges(1);
        chk_en = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk); @(negedge clk);
        reset = 1;
        chk_en = 1;
        wait_edges(100);
        chk("idle_msec", o_msec, 0);
        chk("idle_hour", o_hour, 0);
        chk("idle_run", o_running, 0);

        step(1, 0, 0);
        chk("run_rise", o_running, 1);
        wait_edges(9);
        chk("ms_at9", o_msec, 0);
        wait_edges(1);
        chk("ms_at10", o_msec, 1);
        wait_edges(40);
        chk("ms_at50", o_msec, 5);

        step(0, 1, 0);
        wait_edges(9);
        chk("clr_in_run", o_msec, 6);
        wait_edges(3);
        step(1, 0, 0);
        chk("stop_run", o_running, 0);
        wait_edges(30);
        chk("stop_hold", o_msec, 6);
        step(1, 0, 0);
        wait_edges(5);
        chk("resume_5", o_msec, 6);
        wait_edges(1);
        chk("resume_6", o_msec, 7);

        step(1, 0, 0);
        step(1, 1, 0);
        chk("clr_pri_run", o_running, 0);
        wait_edges(1);
        chk("clr_msec", o_msec, 0);
        chk("clr_run", o_running, 0);

        preload(0, 0, 59, 99);
        step(1, 0, 0);
        wait_edges(9);
        chk("pre_sec", o_sec, 59);
        wait_edges(1);
        chk("wrap_min", o_min, 1);
        chk("wrap_sec", o_sec, 0);
        chk("wrap_ms", o_msec, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        wait_edges(1);

        preload(23, 59, 59, 99);
        step(1, 0, 0);
        wait_edges(9);
        chk("day_pre_h", o_hour, 23);
        wait_edges(1);
        chk("day_h", o_hour, 0);
        chk("day_m", o_min, 0);
        chk("day_s", o_sec, 0);
        chk("day_ms", o_msec, 0);
        step(1, 0, 0);

`ifdef STOPWATCH_LAP_EN
        step(0, 1, 0);
        wait_edges(1);
        step(1, 0, 0);
        wait_edges(1200);
        chk("lap_pre_ms", o_msec, 20);
        step(0, 0, 1);
        wait_edges(499);
        chk("lap_frz_s", o_sec, 1);
        chk("lap_frz_ms", o_msec, 20);
        step(0, 0, 1);
        chk("lap_live_s", o_sec, 1);
        chk("lap_live_ms", o_msec, 70);
        step(0, 0, 1);
        wait_edges(3);
        #2 reset = 0;
        #1;
        chk("rst_ms", o_msec, 0);
        chk("rst_s", o_sec, 0);
        chk("rst_run", o_running, 0);
        @(negedge clk);
        reset = 1;
        wait_edges(2);
        chk("post_rst", o_msec, 0);
`endif

        wait_edges(2);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
